// File: rtl/cp0_reg_file_pkg.sv
// Shared CP0 definitions: register indices, exception codes, Status/Cause
// bit positions, writable-field masks and reset constants.
package cp0_reg_file_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [4:0] {
        CP0_REG_BADVADDR = 5'd8,
        CP0_REG_COUNT    = 5'd9,
        CP0_REG_COMPARE  = 5'd11,
        CP0_REG_STATUS   = 5'd12,
        CP0_REG_CAUSE    = 5'd13,
        CP0_REG_EPC      = 5'd14,
        CP0_REG_PRID     = 5'd15
    } cp0_reg_e;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int unsigned STATUS_IE_BIT  = 0;
    localparam int unsigned STATUS_EXL_BIT = 1;

    // MTC0 only touches these bits; everything else keeps its old value.
    localparam logic [XLEN-1:0] STATUS_WMASK = 32'h0000_FF03;

    localparam logic [XLEN-1:0] PRID_VALUE_DEFAULT   = 32'h0000_4220;
    localparam logic [XLEN-1:0] STATUS_RESET_DEFAULT = 32'h0040_0000;

    function automatic logic [XLEN-1:0] merge_masked(
        input logic [XLEN-1:0] old_val,
        input logic [XLEN-1:0] new_val,
        input logic [XLEN-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // Address-error exceptions are the only ones that record BadVAddr.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_reg_file_if.sv
// MTC0 write port and combinational CP0 read port.
//   we_i/waddr_i/wdata_i : MTC0 commit from WB
//   raddr_i/rdata_o      : read of committed register (unimplemented -> 0)
interface cp0_reg_file_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;

    modport master (output we_i, waddr_i, wdata_i, raddr_i, input rdata_o);
    modport slave  (input we_i, waddr_i, wdata_i, raddr_i, output rdata_o);
endinterface

// File: rtl/cp0_reg_file_timer.sv
// CP0 timer: Count, Compare, half-rate tick flop and sticky timer pending.
//   count_we_i/compare_we_i : MTC0 to Count/Compare with wdata_i
//   count_o/compare_o       : committed values
//   timer_int_o             : set on Count==Compare (Compare!=0), cleared by
//                             any MTC0 to Compare
module cp0_timer
    import cp0_reg_file_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            count_we_i,
    input  logic            compare_we_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] count_o,
    output logic [XLEN-1:0] compare_o,
    output logic            timer_int_o
);

    logic            tick_q, tick_d;
    logic [XLEN-1:0] count_q, count_d;
    logic [XLEN-1:0] compare_q, compare_d;
    logic            timer_int_q, timer_int_d;

    always_comb begin
        tick_d      = ~tick_q;
        count_d     = count_q;
        compare_d   = compare_q;
        timer_int_d = timer_int_q;

        // A Count write restarts the half-rate phase.
        if (count_we_i) begin
            count_d = wdata_i;
            tick_d  = 1'b0;
        end else if (tick_q) begin
            count_d = count_q + 32'd1;
        end

        // Match uses the incoming Count value; a Compare write wins over it.
        if (compare_we_i) begin
            compare_d   = wdata_i;
            timer_int_d = 1'b0;
        end else if ((count_d == compare_q) && (compare_q != '0)) begin
            timer_int_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q      <= 1'b0;
            count_q     <= '0;
            compare_q   <= '0;
            timer_int_q <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_reg_file.sv
// Coprocessor 0 register file: committed CP0 state with MTC0 writes,
// exception entry, ERET, timer and hardware interrupt sampling.
//   bus            : MTC0 write port and combinational read port
//   exc_*_i        : exception taken this cycle and its attributes
//   eret_i         : ERET committing this cycle
//   hw_int_i       : level-sensitive external interrupt lines
//   *_o            : committed Count/Compare/Status/Cause/EPC values,
//                    interrupt request and timer pending flag
module cp0_reg_file
    import cp0_reg_file_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE   = PRID_VALUE_DEFAULT,
    parameter logic [31:0] STATUS_RESET = STATUS_RESET_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    cp0_reg_file_if.slave   bus,
    input  logic            exc_valid_i,
    input  logic [4:0]      exc_code_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic            exc_bd_i,
    input  logic [XLEN-1:0] exc_badvaddr_i,
    input  logic            eret_i,
    input  logic [5:0]      hw_int_i,
    output logic [XLEN-1:0] count_o,
    output logic [XLEN-1:0] compare_o,
    output logic [XLEN-1:0] status_o,
    output logic [XLEN-1:0] cause_o,
    output logic [XLEN-1:0] epc_o,
    output logic            int_req_o,
    output logic            timer_int_o
);

    logic [XLEN-1:0] status_q, status_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] badvaddr_q, badvaddr_d;
    logic            bd_q, bd_d;
    logic [4:0]      exccode_q, exccode_d;
    logic [5:0]      ip_hw_q, ip_hw_d;
    logic [1:0]      ip_sw_q, ip_sw_d;

    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [XLEN-1:0] cause_val;

    assign wr_count   = bus.we_i && (bus.waddr_i == CP0_REG_COUNT);
    assign wr_compare = bus.we_i && (bus.waddr_i == CP0_REG_COMPARE);
    assign wr_status  = bus.we_i && (bus.waddr_i == CP0_REG_STATUS);
    assign wr_cause   = bus.we_i && (bus.waddr_i == CP0_REG_CAUSE);
    assign wr_epc     = bus.we_i && (bus.waddr_i == CP0_REG_EPC);

    cp0_timer u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .count_we_i   (wr_count),
        .compare_we_i (wr_compare),
        .wdata_i      (bus.wdata_i),
        .count_o      (count_o),
        .compare_o    (compare_o),
        .timer_int_o  (timer_int_o)
    );

    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_hw_d    = hw_int_i;
        ip_sw_d    = ip_sw_q;

        // MTC0 first; exception/ERET then override the fields they own.
        if (wr_status) status_d = merge_masked(status_q, bus.wdata_i, STATUS_WMASK);
        if (wr_cause)  ip_sw_d  = bus.wdata_i[9:8];
        if (wr_epc)    epc_d    = bus.wdata_i;

        if (exc_valid_i) begin
            // Nested exceptions keep the original return point.
            if (!status_d[STATUS_EXL_BIT]) begin
                epc_d = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
                bd_d  = exc_bd_i;
            end
            status_d[STATUS_EXL_BIT] = 1'b1;
            exccode_d = exc_code_i;
            if (is_addr_exc(exc_code_i)) badvaddr_d = exc_badvaddr_i;
        end else if (eret_i) begin
            status_d[STATUS_EXL_BIT] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q   <= STATUS_RESET;
            epc_q      <= '0;
            badvaddr_q <= '0;
            bd_q       <= 1'b0;
            exccode_q  <= '0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
        end
    end

    // IP[15] shares the top hardware line with the timer pending flag.
    assign cause_val = {bd_q, 15'b0, ip_hw_q[5] | timer_int_o, ip_hw_q[4:0],
                        ip_sw_q, 1'b0, exccode_q, 2'b00};

    assign status_o  = status_q;
    assign cause_o   = cause_val;
    assign epc_o     = epc_q;
    assign int_req_o = status_q[STATUS_IE_BIT] & ~status_q[STATUS_EXL_BIT]
                     & |(cause_val[15:8] & status_q[15:8]);

    always_comb begin
        bus.rdata_o = '0;
        case (bus.raddr_i)
            CP0_REG_BADVADDR: bus.rdata_o = badvaddr_q;
            CP0_REG_COUNT:    bus.rdata_o = count_o;
            CP0_REG_COMPARE:  bus.rdata_o = compare_o;
            CP0_REG_STATUS:   bus.rdata_o = status_q;
            CP0_REG_CAUSE:    bus.rdata_o = cause_val;
            CP0_REG_EPC:      bus.rdata_o = epc_q;
            CP0_REG_PRID:     bus.rdata_o = PRID_VALUE;
            default:          bus.rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg_file.sv
module tb_cp0_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [5:0]  hw_int;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o;
    logic        int_req_o, timer_int_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cp0_reg_file_if bus ();

    cp0_reg_file dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .exc_valid_i    (exc_valid),
        .exc_code_i     (exc_code),
        .exc_pc_i       (exc_pc),
        .exc_bd_i       (exc_bd),
        .exc_badvaddr_i (exc_badvaddr),
        .eret_i         (eret),
        .hw_int_i       (hw_int),
        .count_o        (count_o),
        .compare_o      (compare_o),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .int_req_o      (int_req_o),
        .timer_int_o    (timer_int_o)
    );

    // Reference model: architectural registers updated once per clock.
    logic [31:0] m_count, m_compare, m_status, m_epc, m_badv;
    logic        m_bd, m_timer;
    logic [4:0]  m_exccode;
    logic [5:0]  m_hw;
    logic [1:0]  m_ipsw;
    int unsigned m_cycles_since_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_compare = 0; m_status = 32'h0040_0000; m_epc = 0; m_badv = 0;
        m_bd = 0; m_timer = 0; m_exccode = 0; m_hw = 0; m_ipsw = 0;
        m_cycles_since_count = 0;
    endtask

    function automatic logic [31:0] model_cause();
        logic [31:0] c;
        c = 32'(m_bd) << 31;
        c = c | (32'(m_hw) << 10) | (32'(m_timer) << 15) | (32'(m_ipsw) << 8);
        c = c | (32'(m_exccode) << 2);
        return c;
    endfunction

    function automatic logic model_int_req();
        logic [31:0] pend;
        pend = (model_cause() >> 8) & (m_status >> 8) & 32'hFF;
        return m_status[0] && !m_status[1] && (pend != 0);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return model_cause();
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_4220;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wd, new_count;
        wr = bus.we_i; wa = bus.waddr_i; wd = bus.wdata_i;

        // Count advances on every second clock counted from reset/last write.
        if (wr && wa == 5'd9) begin
            new_count = wd;
            m_cycles_since_count = 0;
        end else begin
            new_count = (m_cycles_since_count % 2 == 1) ? m_count + 1 : m_count;
            m_cycles_since_count++;
        end
        if (wr && wa == 5'd11) begin
            m_timer   = 0;
            m_compare = wd;
        end else if (new_count == m_compare && m_compare != 0) begin
            m_timer = 1;
        end
        m_count = new_count;

        if (wr && wa == 5'd12) m_status = (m_status & ~32'h0000_FF03) | (wd & 32'h0000_FF03);
        if (wr && wa == 5'd13) m_ipsw = wd[9:8];
        if (wr && wa == 5'd14) m_epc = wd;
        m_hw = hw_int;

        if (exc_valid) begin
            if (!m_status[1]) begin
                m_epc = exc_bd ? exc_pc - 4 : exc_pc;
                m_bd  = exc_bd;
            end
            m_status[1] = 1;
            m_exccode   = exc_code;
            if (exc_code == 5'd4 || exc_code == 5'd5) m_badv = exc_badvaddr;
        end else if (eret) begin
            m_status[1] = 0;
        end
    endtask

    task automatic check_all();
        chk("count",   count_o,   m_count);
        chk("compare", compare_o, m_compare);
        chk("status",  status_o,  m_status);
        chk("cause",   cause_o,   model_cause());
        chk("epc",     epc_o,     m_epc);
        chk("timer",   32'(timer_int_o), 32'(m_timer));
        chk("int_req", 32'(int_req_o),   32'(model_int_req()));
        chk("rdata",   bus.rdata_o, model_read(bus.raddr_i));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we_i = 1; bus.waddr_i = a; bus.wdata_i = d;
        cycle();
        bus.we_i = 0;
    endtask

    task automatic take_exc(input logic [4:0] code, input logic [31:0] pc,
                            input logic bd, input logic [31:0] badv, input logic with_eret);
        exc_valid = 1; exc_code = code; exc_pc = pc; exc_bd = bd; exc_badvaddr = badv;
        eret = with_eret;
        cycle();
        exc_valid = 0; eret = 0;
    endtask

    initial begin
        rst_n = 0;
        bus.we_i = 0; bus.waddr_i = 0; bus.wdata_i = 0; bus.raddr_i = 5'd12;
        exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0; exc_badvaddr = 0;
        eret = 0; hw_int = 0;
        model_reset();
        repeat (2) @(negedge clk);

        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_count", count_o, 32'h0);
        chk("rst_cause", cause_o, 32'h0);
        chk("rst_int_req", 32'(int_req_o), 32'h0);
        rst_n = 1;
        check_all();

        mtc0(5'd12, 32'hFFFF_FFFF);
        chk("status_mask", status_o, 32'h0040_FF03);
        mtc0(5'd13, 32'hFFFF_FFFF);
        chk("cause_mask", cause_o, 32'h0000_0300);
        mtc0(5'd12, 32'h0);

        // Timer: Count reaches Compare=10 twenty clocks after the Count write.
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd10);
        repeat (19) cycle();
        chk("timer_count", count_o, 32'd10);
        chk("timer_set", 32'(timer_int_o), 32'h1);
        chk("timer_ip7", 32'(cause_o[15]), 32'h1);
        mtc0(5'd11, 32'd50);
        chk("timer_clr", 32'(timer_int_o), 32'h0);

        // Exceptions, nested exception, ERET.
        bus.raddr_i = 5'd8;
        take_exc(5'd4, 32'h8000_0104, 1'b1, 32'h0000_1235, 1'b0);
        chk("exc_epc", epc_o, 32'h8000_0100);
        chk("exc_bd", 32'(cause_o[31]), 32'h1);
        chk("exc_code", 32'(cause_o[6:2]), 32'd4);
        chk("exc_badv", bus.rdata_o, 32'h0000_1235);
        chk("exc_exl", 32'(status_o[1]), 32'h1);
        take_exc(5'd8, 32'h8000_0200, 1'b0, 32'h0000_9999, 1'b0);
        chk("exc2_epc", epc_o, 32'h8000_0100);
        chk("exc2_code", 32'(cause_o[6:2]), 32'd8);
        chk("exc2_badv", bus.rdata_o, 32'h0000_1235);
        eret = 1; cycle(); eret = 0;
        chk("eret_exl", 32'(status_o[1]), 32'h0);
        take_exc(5'd8, 32'h8000_0300, 1'b0, 32'h0, 1'b1);
        chk("exc_eret_exl", 32'(status_o[1]), 32'h1);

        // Interrupt request path.
        mtc0(5'd12, 32'h0000_0401);
        chk("int_idle", 32'(int_req_o), 32'h0);
        hw_int = 6'b000001;
        cycle();
        chk("int_req", 32'(int_req_o), 32'h1);
        mtc0(5'd12, 32'h0000_0403);
        chk("int_exl_mask", 32'(int_req_o), 32'h0);
        hw_int = 0;
        mtc0(5'd12, 32'h0);

        // Count wrap.
        mtc0(5'd9, 32'hFFFF_FFFF);
        cycle();
        chk("wrap_hold", count_o, 32'hFFFF_FFFF);
        cycle();
        chk("wrap_zero", count_o, 32'h0);

        // Compare write on the match cycle: clear wins; sets on the next one.
        mtc0(5'd11, 32'd7);
        mtc0(5'd9, 32'd6);
        cycle();
        mtc0(5'd11, 32'd7);
        chk("cmp_clear_wins", 32'(timer_int_o), 32'h0);
        chk("cmp_count", count_o, 32'd7);
        cycle();
        chk("cmp_set_after", 32'(timer_int_o), 32'h1);

        // Compare of zero never matches.
        mtc0(5'd11, 32'h0);
        mtc0(5'd9, 32'h0);
        chk("cmp_zero", 32'(timer_int_o), 32'h0);

        // Read-only registers and unimplemented index.
        mtc0(5'd8, 32'hDEAD_BEEF);
        mtc0(5'd15, 32'hDEAD_BEEF);
        bus.raddr_i = 5'd8;  #1 chk("ro_badv", bus.rdata_o, 32'h0000_1235);
        bus.raddr_i = 5'd15; #1 chk("ro_prid", bus.rdata_o, 32'h0000_4220);
        bus.raddr_i = 5'd3;  #1 chk("unimpl", bus.rdata_o, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            int unsigned r;
            bus.we_i = ($urandom_range(0, 9) < 3);
            r = $urandom_range(0, 9);
            case (r)
                0: bus.waddr_i = 5'd8;
                1: bus.waddr_i = 5'd9;
                2: bus.waddr_i = 5'd11;
                3: bus.waddr_i = 5'd12;
                4: bus.waddr_i = 5'd13;
                5: bus.waddr_i = 5'd14;
                6: bus.waddr_i = 5'd15;
                default: bus.waddr_i = 5'($urandom);
            endcase
            bus.wdata_i = $urandom;
            if (bus.waddr_i == 5'd9 && $urandom_range(0, 1) == 1)
                bus.wdata_i = m_compare - $urandom_range(0, 4);
            if (bus.waddr_i == 5'd11 && $urandom_range(0, 1) == 1)
                bus.wdata_i = m_count + $urandom_range(0, 6);
            exc_valid = ($urandom_range(0, 9) == 0);
            eret      = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 5);
            case (r)
                0: exc_code = 5'd0;
                1: exc_code = 5'd4;
                2: exc_code = 5'd5;
                3: exc_code = 5'd8;
                4: exc_code = 5'd10;
                default: exc_code = 5'd12;
            endcase
            exc_pc       = $urandom & 32'hFFFF_FFFC;
            exc_bd       = 1'($urandom);
            exc_badvaddr = $urandom;
            if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
            bus.raddr_i  = 5'($urandom_range(7, 16));
            cycle();
        end
        bus.we_i = 0; exc_valid = 0; eret = 0;

        // Asynchronous reset mid-operation with a write and exception pending.
        bus.we_i = 1; bus.waddr_i = 5'd12; bus.wdata_i = 32'hFFFF_FFFF;
        exc_valid = 1; exc_code = 5'd4; exc_badvaddr = 32'h5555_0000;
        #2 rst_n = 0;
        #1;
        chk("arst_status", status_o, 32'h0040_0000);
        chk("arst_count", count_o, 32'h0);
        chk("arst_epc", epc_o, 32'h0);
        chk("arst_timer", 32'(timer_int_o), 32'h0);
        @(negedge clk);
        bus.we_i = 0; exc_valid = 0; hw_int = 0;
        model_reset();
        check_all();
        rst_n = 1;
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
